// File: rtl/register_bank_pkg.sv
// Shared widths, index/data types and the hardwired-zero index for the multi-port register bank.
package register_bank_pkg;

  localparam int RB_DATA_W = 32;
  localparam int RB_ADDR_W = 5;

  typedef logic [RB_DATA_W-1:0] reg_data_t;
  typedef logic [RB_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_IDX = {RB_ADDR_W{1'b0}};

endpackage

// File: rtl/rb_scoreboard.sv
// Per-register pending flags: writes clear, issue sets, set beats clear on the same index.
module rb_scoreboard
  import register_bank_pkg::*;
#(
  parameter int ADDR_W   = RB_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr0_en,
  input  logic [ADDR_W-1:0] clr0_addr,
  input  logic              clr1_en,
  input  logic [ADDR_W-1:0] clr1_addr,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] look_addr1,
  input  logic [ADDR_W-1:0] look_addr2,
  output logic              busy1,
  output logic              busy2
);

  logic [NUM_REGS-1:0] pend_r;
  logic [NUM_REGS-1:0] pend_nxt_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] set_mask_s;

  function automatic logic [NUM_REGS-1:0] onehot(input logic en, input logic [ADDR_W-1:0] a);
    return en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << a) : {NUM_REGS{1'b0}};
  endfunction

  // Next pending vector: clears applied first so a same-index set survives.
  always_comb begin
    clr_mask_s = onehot(clr0_en, clr0_addr) | onehot(clr1_en, clr1_addr);
    set_mask_s = onehot(set_en, set_addr);
    pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
  end

  // Pending flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= {NUM_REGS{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // Busy lookups for both read ports.
  always_comb begin
    busy1 = pend_r[look_addr1];
    busy2 = pend_r[look_addr2];
  end

endmodule

// File: rtl/register_bank_mp.sv
// Two-read / two-write register bank with pending scoreboard for the KGP-RISC datapath.
// Define RB_BYPASS_EN to forward same-cycle writes (and their scoreboard clears) to the read ports.
module register_bank_mp
  import register_bank_pkg::*;
#(
  parameter int DATA_W   = RB_DATA_W,
  parameter int ADDR_W   = RB_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [NUM_REGS];
  logic              wr0_ok_s;
  logic              wr1_ok_s;
  logic              set_ok_s;
  logic              pend_busy1_s;
  logic              pend_busy2_s;
  logic              clr_hit1_s;
  logic              clr_hit2_s;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_IDX));
  endfunction

  // Qualified write/set strobes; wr0 yields to wr1 on a shared index.
  always_comb begin
    wr1_ok_s = wr1_en && !is_zero(wr1_addr);
    wr0_ok_s = wr0_en && !is_zero(wr0_addr) && !(wr1_ok_s && (wr1_addr == wr0_addr));
    set_ok_s = sb_set && !is_zero(sb_addr);
  end

  // Register array storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr0_ok_s) begin
        mem_r[wr0_addr] <= wr0_data;
      end
      if (wr1_ok_s) begin
        mem_r[wr1_addr] <= wr1_data;
      end
    end
  end

  rb_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .clr0_en    (wr0_ok_s),
    .clr0_addr  (wr0_addr),
    .clr1_en    (wr1_ok_s),
    .clr1_addr  (wr1_addr),
    .set_en     (set_ok_s),
    .set_addr   (sb_addr),
    .look_addr1 (rd_addr1),
    .look_addr2 (rd_addr2),
    .busy1      (pend_busy1_s),
    .busy2      (pend_busy2_s)
  );

  // Read port 1 data, with optional forwarding (wr1 has priority over wr0).
  always_comb begin
    if (is_zero(rd_addr1)) begin
      rd_data1 = {DATA_W{1'b0}};
`ifdef RB_BYPASS_EN
    end else if (!reset && wr1_ok_s && (wr1_addr == rd_addr1)) begin
      rd_data1 = wr1_data;
    end else if (!reset && wr0_ok_s && (wr0_addr == rd_addr1)) begin
      rd_data1 = wr0_data;
`endif
    end else begin
      rd_data1 = mem_r[rd_addr1];
    end
  end

  // Read port 2 data, mirror of port 1.
  always_comb begin
    if (is_zero(rd_addr2)) begin
      rd_data2 = {DATA_W{1'b0}};
`ifdef RB_BYPASS_EN
    end else if (!reset && wr1_ok_s && (wr1_addr == rd_addr2)) begin
      rd_data2 = wr1_data;
    end else if (!reset && wr0_ok_s && (wr0_addr == rd_addr2)) begin
      rd_data2 = wr0_data;
`endif
    end else begin
      rd_data2 = mem_r[rd_addr2];
    end
  end

  // A same-cycle write hides the pending bit unless a new producer is issued to that index.
  always_comb begin
`ifdef RB_BYPASS_EN
    clr_hit1_s = !reset
               && ((wr0_ok_s && (wr0_addr == rd_addr1)) || (wr1_ok_s && (wr1_addr == rd_addr1)))
               && !(set_ok_s && (sb_addr == rd_addr1));
    clr_hit2_s = !reset
               && ((wr0_ok_s && (wr0_addr == rd_addr2)) || (wr1_ok_s && (wr1_addr == rd_addr2)))
               && !(set_ok_s && (sb_addr == rd_addr2));
`else
    clr_hit1_s = 1'b0;
    clr_hit2_s = 1'b0;
`endif
    rd_busy1 = !is_zero(rd_addr1) && pend_busy1_s && !clr_hit1_s;
    rd_busy2 = !is_zero(rd_addr2) && pend_busy2_s && !clr_hit2_s;
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Self-checking bench for register_bank_mp: directed vector table, bypass sequences, random vs model.
module tb_register_bank_mp;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic        wr0_en, wr1_en, sb_set;
  logic [4:0]  wr0_addr, wr1_addr, sb_addr;
  logic [31:0] wr0_data, wr1_data;

  int checks = 0;
  int errors = 0;

  register_bank_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents and pending flags.
  logic [31:0] m_mem [32];
  logic        m_pend [32];

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_mem[i] = 32'd0; m_pend[i] = 1'b0; end
    end else begin
      for (int i = 1; i < 32; i++) begin
        logic w0, w1, st;
        w0 = wr0_en && (int'(wr0_addr) == i);
        w1 = wr1_en && (int'(wr1_addr) == i);
        st = sb_set && (int'(sb_addr) == i);
        if (w1) m_mem[i] = wr1_data;
        else if (w0) m_mem[i] = wr0_data;
        if (st) m_pend[i] = 1'b1;
        else if (w0 || w1) m_pend[i] = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] exp_data(input int a);
    if (a == 0) return 32'd0;
`ifdef RB_BYPASS_EN
    if (!reset && wr1_en && int'(wr1_addr) == a) return wr1_data;
    if (!reset && wr0_en && int'(wr0_addr) == a) return wr0_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef RB_BYPASS_EN
    if (!reset && ((wr0_en && int'(wr0_addr) == a) || (wr1_en && int'(wr1_addr) == a))
        && !(sb_set && int'(sb_addr) == a)) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; sb_set = 1'b0;
    wr0_addr = 5'd0; wr1_addr = 5'd0; sb_addr = 5'd0;
    wr0_data = 32'd0; wr1_data = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic        sse; logic [4:0] ssa;
    logic [4:0]  ra1, ra2;
    logic [31:0] ed1; logic eb1;
    logic [31:0] ed2; logic eb2;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input logic rst, input logic w0e, input logic [4:0] w0a,
                              input logic [31:0] w0d, input logic w1e, input logic [4:0] w1a,
                              input logic [31:0] w1d, input logic sse, input logic [4:0] ssa,
                              input logic [4:0] ra1, input logic [31:0] ed1, input logic eb1,
                              input logic [4:0] ra2, input logic [31:0] ed2, input logic eb2);
    vec_t v;
    v.rst = rst; v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d; v.sse = sse; v.ssa = ssa;
    v.ra1 = ra1; v.ed1 = ed1; v.eb1 = eb1; v.ra2 = ra2; v.ed2 = ed2; v.eb2 = eb2;
    return v;
  endfunction

  initial begin
    // Expected values describe reads one cycle after the vector, with all writes idle.
    vecs[0]  = mk(1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,    1'b0, 5'd0,
                  5'd5, 32'h0, 1'b0,         5'd3,  32'h0,    1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 5'd7, 32'h1111,      1'b1, 5'd7,  32'h2222, 1'b0, 5'd0,
                  5'd7, 32'h2222, 1'b0,      5'd7,  32'h2222, 1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,    1'b1, 5'd0,
                  5'd0, 32'h0, 1'b0,         5'd0,  32'h0,    1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 5'd3,
                  5'd3, 32'h0, 1'b1,         5'd7,  32'h2222, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd3,  32'h0A,   1'b0, 5'd0,
                  5'd3, 32'h0A, 1'b0,        5'd3,  32'h0A,   1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 5'd3, 32'h0B,        1'b0, 5'd0,  32'h0,    1'b1, 5'd3,
                  5'd3, 32'h0B, 1'b1,        5'd7,  32'h2222, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,
                  5'd5, 32'hDEAD_BEEF, 1'b0, 5'd3,  32'h0B,   1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,    1'b0, 5'd0,
                  5'd5, 32'h0, 1'b0,         5'd3,  32'h0,    1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd4,  32'h99,   1'b1, 5'd6,
                  5'd4, 32'h99, 1'b0,        5'd6,  32'h0,    1'b1);
    vecs[9]  = mk(1'b1, 1'b1, 5'd4, 32'h77,        1'b0, 5'd0,  32'h0,    1'b1, 5'd4,
                  5'd4, 32'h0, 1'b0,         5'd6,  32'h0,    1'b0);
    vecs[10] = mk(1'b0, 1'b1, 5'd9, 32'h55,        1'b1, 5'd10, 32'h66,   1'b0, 5'd0,
                  5'd9, 32'h55, 1'b0,        5'd10, 32'h66,   1'b0);

    idle();
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    reset = 1'b1;
    step(); step();
    idle();

    for (int v = 0; v < 11; v++) begin
      reset = vecs[v].rst;
      wr0_en = vecs[v].w0e; wr0_addr = vecs[v].w0a; wr0_data = vecs[v].w0d;
      wr1_en = vecs[v].w1e; wr1_addr = vecs[v].w1a; wr1_data = vecs[v].w1d;
      sb_set = vecs[v].sse; sb_addr = vecs[v].ssa;
      step();
      idle();
      rd_addr1 = vecs[v].ra1; rd_addr2 = vecs[v].ra2;
      @(negedge clk);
      check($sformatf("vec%0d_data1", v), rd_data1, vecs[v].ed1);
      check($sformatf("vec%0d_busy1", v), {31'd0, rd_busy1}, {31'd0, vecs[v].eb1});
      check($sformatf("vec%0d_data2", v), rd_data2, vecs[v].ed2);
      check($sformatf("vec%0d_busy2", v), {31'd0, rd_busy2}, {31'd0, vecs[v].eb2});
    end

    // Same-cycle write and read of r11: forwarded only with bypass.
    idle();
    wr0_en = 1'b1; wr0_addr = 5'd11; wr0_data = 32'h33;
    step();
    wr0_data = 32'h55; rd_addr1 = 5'd11;
    @(negedge clk);
`ifdef RB_BYPASS_EN
    check("bypass_same_cycle", rd_data1, 32'h55);
`else
    check("bypass_same_cycle", rd_data1, 32'h33);
`endif
    step();
    idle();
    @(negedge clk);
    check("bypass_next_cycle", rd_data1, 32'h55);

    // Pending bit hidden by a clearing write in the same cycle only with bypass.
    sb_set = 1'b1; sb_addr = 5'd12;
    step();
    idle();
    wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'hC0DE; rd_addr2 = 5'd12;
    @(negedge clk);
`ifdef RB_BYPASS_EN
    check("busy_bypass_clear", {31'd0, rd_busy2}, 32'd0);
`else
    check("busy_bypass_clear", {31'd0, rd_busy2}, 32'd1);
`endif
    step();
    idle();
    sb_set = 1'b1; sb_addr = 5'd12; wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'hBEEF;
    @(negedge clk);
    check("busy_set_and_write_same", {31'd0, rd_busy2}, 32'd0);
    step();
    idle();
    @(negedge clk);
    check("busy_set_wins", {31'd0, rd_busy2}, 32'd1);
    check("data_after_set_write", rd_data2, 32'hBEEF);

    // Random traffic on a small index range to force collisions.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      reset    = ($urandom_range(0, 39) == 0);
      wr0_en   = $urandom_range(0, 1) == 1;
      wr0_addr = 5'($urandom_range(0, 7));
      wr0_data = $urandom;
      wr1_en   = $urandom_range(0, 2) == 0;
      wr1_addr = 5'($urandom_range(0, 7));
      wr1_data = $urandom;
      sb_set   = $urandom_range(0, 1) == 1;
      sb_addr  = 5'($urandom_range(0, 7));
      rd_addr1 = 5'($urandom_range(0, 7));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? wr0_addr : 5'($urandom_range(0, 31));
      @(negedge clk);
      check("rand_data1", rd_data1, exp_data(int'(rd_addr1)));
      check("rand_data2", rd_data2, exp_data(int'(rd_addr2)));
      check("rand_busy1", {31'd0, rd_busy1}, {31'd0, exp_busy(int'(rd_addr1))});
      check("rand_busy2", {31'd0, rd_busy2}, {31'd0, exp_busy(int'(rd_addr2))});
      @(posedge clk);
      model_edge();
      #1;
      idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
